// File: rtl/seq_frame_tx_01110.sv
// Serial frame transmitter: sync field 0,1,1,1,0 followed by an MSB-first payload
// with a 0 stuffed after every pair of 1s, so 01110 only ever appears as the sync.
module seq_frame_tx_01110 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SYNC = 2'b01,
        S_DATA = 2'b10
    } state_t;

    localparam int            CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);
    // Palindromic, so the sync index can address it directly.
    localparam logic [4:0]    SYNC_PAT = 5'b01110;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [1:0]        ones_cnt, ones_nxt;
    logic [CW-1:0]     bit_cnt, bit_nxt;
    logic [2:0]        sync_idx, sync_nxt;
    logic              dout_nxt, en_nxt, done_nxt;
    logic              emit_payload;

    // Counters describe the bit currently on dout; ones_cnt counts the 1s ending it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            shreg    <= '0;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            sync_idx <= '0;
            dout     <= 1'b0;
            dout_en  <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            ones_cnt <= ones_nxt;
            bit_cnt  <= bit_nxt;
            sync_idx <= sync_nxt;
            dout     <= dout_nxt;
            dout_en  <= en_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-value gets a default first so no latch is inferred.
        state_nxt    = state;
        shreg_nxt    = shreg;
        ones_nxt     = ones_cnt;
        bit_nxt      = bit_cnt;
        sync_nxt     = sync_idx;
        dout_nxt     = 1'b0;
        en_nxt       = 1'b0;
        done_nxt     = 1'b0;
        emit_payload = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    state_nxt = S_SYNC;
                    shreg_nxt = tx_data;
                    ones_nxt  = '0;
                    bit_nxt   = '0;
                    sync_nxt  = '0;
                    dout_nxt  = SYNC_PAT[0];
                    en_nxt    = 1'b1;
                end
            end

            S_SYNC: begin
                if (sync_idx != 3'd4) begin
                    sync_nxt = sync_idx + 3'd1;
                    dout_nxt = SYNC_PAT[sync_nxt];
                    en_nxt   = 1'b1;
                end else begin
                    state_nxt    = S_DATA;
                    emit_payload = 1'b1;
                end
            end

            S_DATA: begin
                // Stuffing takes priority over ending so a trailing 1,1 still gets its 0.
                if (ones_cnt == 2'd2) begin
                    ones_nxt = '0;
                    en_nxt   = 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    emit_payload = 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        if (emit_payload) begin
            dout_nxt  = shreg[DATA_W-1];
            en_nxt    = 1'b1;
            shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
            ones_nxt  = shreg[DATA_W-1] ? ones_cnt + 2'd1 : 2'd0;
            bit_nxt   = bit_cnt + CW'(1);
        end
    end

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state == S_SYNC) || (state == S_DATA);

endmodule

// File: tb/tb_seq_frame_tx_01110.sv
// Bench for seq_frame_tx_01110: a queue-based frame model compared every cycle,
// directed frames with literal lengths, mid-frame reset and a random back-to-back run.
module tb_seq_frame_tx_01110;

    localparam int DW = 8;
    typedef bit bit_q_t[$];

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, dout, dout_en, busy, done;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    seq_frame_tx_01110 #(.DATA_W(DW)) dut (
        .clk     (clk),
        .clr     (clr),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .dout    (dout),
        .dout_en (dout_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit list: sync, then payload with a 0 inserted after any two 1s in a row.
    function automatic bit_q_t build_frame(input logic [DW-1:0] w);
        bit_q_t q;
        int     run = 0;
        q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = DW - 1; i >= 0; i--) begin
            q.push_back(w[i]);
            run = w[i] ? run + 1 : 0;
            if (run == 2) begin
                q.push_back(1'b0);
                run = 0;
            end
        end
        return q;
    endfunction

    function automatic logic [31:0] pack(input bit_q_t q);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Model: exp_q holds the bits still to appear, front = bit on dout this cycle.
    bit_q_t exp_q;
    bit     m_done = 1'b0;
    int     m_len  = 0;
    int     det_cnt = 0;
    int     sync_seen = 0;
    logic [4:0] hist = '0;

    always @(negedge clr) begin
        exp_q.delete();
        m_done = 1'b0;
    end

    always @(posedge clk) begin
        if (clr) begin
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                m_done = (exp_q.size() == 0);
            end else begin
                m_done = 1'b0;
                if (tx_valid === 1'b1) begin
                    exp_q = build_frame(tx_data);
                    m_len = exp_q.size();
                    n_vec++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            check("rst_dout_en", {31'b0, dout_en}, 32'd0);
            check("rst_dout", {31'b0, dout}, 32'd0);
            check("rst_done", {31'b0, done}, 32'd0);
        end else begin
            check("dout_en", {31'b0, dout_en}, {31'b0, exp_q.size() != 0});
            check("dout", {31'b0, dout}, {31'b0, (exp_q.size() != 0) ? exp_q[0] : 1'b0});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("tx_ready", {31'b0, tx_ready}, {31'b0, exp_q.size() == 0});
            check("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0 && (m_len - exp_q.size()) == 4) sync_seen++;
            if (dout_en === 1'b1) begin
                hist = {hist[3:0], dout};
                if (hist == 5'b01110) begin
                    det_cnt++;
                    check("detect_at_sync", m_len - exp_q.size(), 32'd4);
                end
            end
        end
    end

    task automatic wait_done(input string name, input int exp_en);
        int  en_cnt = 0;
        bit  seen   = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (dout_en === 1'b1) en_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_frame_len"}, en_cnt, exp_en);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int exp_en, input string name);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = w;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 'x;
        wait_done(name, exp_en);
    endtask

    initial begin
        bit_q_t q;

        // Model pins against hand-derived frames.
        q = build_frame(8'h00);
        check("pin_00_len", q.size(), 32'd13);
        check("pin_00_bits", pack(q), 32'b0111000000000);
        q = build_frame(8'hFF);
        check("pin_ff_len", q.size(), 32'd17);
        check("pin_ff_bits", pack(q), 32'b01110110110110110);
        q = build_frame(8'hE7);
        check("pin_e7_len", q.size(), 32'd15);
        check("pin_e7_bits", pack(q), 32'b011101101001101);

        #2;
        check("reset_en", {31'b0, dout_en}, 32'd0);
        #21 clr = 1'b1;
        #1 check("reset_ready", {31'b0, tx_ready}, 32'd1);

        send_word(8'h00, 13, "w00");
        send_word(8'hFF, 17, "wff");
        send_word(8'hE7, 15, "we7");

        // Busy-time request is ignored, then a held request starts right after done.
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        check("ready_low_in_frame", {31'b0, tx_ready}, 32'd0);
        @(posedge clk); #1;
        tx_data  = 8'h3C;
        wait_done("w00b", 13 - 4);
        @(negedge clk);
        check("b2b_sync_en", {31'b0, dout_en}, 32'd1);
        check("b2b_sync_bit0", {31'b0, dout}, 32'd0);
        #1;
        tx_valid = 1'b0;
        tx_data  = 'x;
        wait_done("w3c", 15 - 1);

        // Reset while the third payload bit of 0xFF is on the line.
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        check("pre_rst_en", {31'b0, dout_en}, 32'd1);
        clr = 1'b0;
        #1;
        check("async_rst_en", {31'b0, dout_en}, 32'd0);
        check("async_rst_dout", {31'b0, dout}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_no_done", {31'b0, done}, 32'd0);
        #3 clr = 1'b1;
        #1 check("post_rst_ready", {31'b0, tx_ready}, 32'd1);
        send_word(8'hE7, 15, "we7_after_rst");

        // Random traffic, including X on tx_data whenever no request is made.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = tx_valid ? DW'($urandom) : 'x;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 'x;
        for (int c = 0; c < 100 && (exp_q.size() != 0 || m_done); c++) @(negedge clk);
        check("drain_idle", {31'b0, exp_q.size() == 0}, 32'd1);
        @(negedge clk);
        check("detections_per_sync", det_cnt, sync_seen);
        check("detections_nonzero", {31'b0, det_cnt > 20}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
